// File: rtl/hash_target_cmp_multi.sv
// hash_target_cmp_multi
// Multi-lane hash/target comparator. Loads a multi-word target serially
// (LS word first), then arbitrates round-robin over LANES FWFT hash FIFOs
// and runs a chunked, MS-first magnitude compare of each head against the
// target. The first hash strictly below the target is the golden hash;
// its nonce and lane are latched.
// Optional debug ports are enabled by defining HASH_CMP_DBG_EN.

module hash_target_cmp_multi #(
  parameter int HASH_W     = 256,
  parameter int TGT_WORD_W = 32,
  parameter int CHUNK_W    = 64,
  parameter int LANES      = 4,
  parameter int NONCE_W    = 32,
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  output logic                       o_stop_ack,
  input  logic [TGT_WORD_W-1:0]      i_target_word,
  input  logic                       i_target_valid,
  output logic                       o_target_ready,
  input  logic                       i_upstream_all_empty,
  input  logic [LANES*HASH_W-1:0]    i_hash_out,
  input  logic [LANES*NONCE_W-1:0]   i_hash_nonce,
  input  logic [LANES-1:0]           i_hash_empty,
  output logic [LANES-1:0]           o_hash_re,
  output logic                       o_result,
  output logic [NONCE_W-1:0]         o_golden_nonce,
  output logic [LANE_W-1:0]          o_golden_lane
`ifdef HASH_CMP_DBG_EN
  ,
  output logic [1:0]                 o_dbg_state,
  output logic [HASH_W-1:0]          o_dbg_target,
  output logic [31:0]                o_dbg_hash_cnt
`endif
);

  localparam int NWORDS = HASH_W / TGT_WORD_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);
  localparam int NCHUNK = HASH_W / CHUNK_W;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_DRAIN       = 2'd0,
    S_LOAD_TARGET = 2'd1,
    S_ARB         = 2'd2,
    S_COMPARE     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [HASH_W-1:0]   r_target;
  logic [CNT_W-1:0]    r_cnt;
  logic [LANE_W-1:0]   r_rrPtr;
  logic [LANE_W-1:0]   r_sel;
  logic [K_W-1:0]      r_k;
  logic                r_result;
  logic [NONCE_W-1:0]  r_goldenNonce;
  logic [LANE_W-1:0]   r_goldenLane;

  logic                w_drainIdle;
  logic                w_startAccept;
  logic                w_targetFire;
  logic                w_cntFull;
  logic                w_arbFound;
  logic [LANE_W-1:0]   w_arbLane;
  logic [LANE_W-1:0]   w_selNext;
  logic [HASH_W-1:0]   w_selHash;
  logic [NONCE_W-1:0]  w_selNonce;
  logic [CHUNK_W-1:0]  w_tChunk;
  logic [CHUNK_W-1:0]  w_hChunk;
  logic                w_gt;
  logic                w_lt;
  logic                w_eq;
  logic                w_lastChunk;
  logic                w_inCompare;
  logic                w_hit;
  logic                w_miss;
  logic                w_arbTake;
  logic                w_chunkAdvance;

  // Handshake and progress qualifiers shared by the FSM and datapath
  assign w_drainIdle    = i_upstream_all_empty & (&i_hash_empty);
  assign w_startAccept  = (r_state == S_DRAIN) & w_drainIdle & i_start;
  assign w_cntFull      = (r_cnt == CNT_W'(NWORDS));
  assign w_targetFire   = o_target_ready & i_target_valid;
  assign w_selNext      = (int'(r_sel) == LANES - 1) ? '0 : r_sel + 1'b1;

  // Round-robin search: first non-empty lane at or after the pointer
  always_comb begin
    w_arbFound = 1'b0;
    w_arbLane  = '0;
    for (int i = 0; i < LANES; i++) begin
      int idx;
      idx = int'(r_rrPtr) + i;
      if (idx >= LANES) idx = idx - LANES;
      if (!w_arbFound && !i_hash_empty[idx]) begin
        w_arbFound = 1'b1;
        w_arbLane  = LANE_W'(idx);
      end
    end
  end

  // Mux the selected lane's head hash and nonce
  always_comb begin
    w_selHash  = '0;
    w_selNonce = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_sel == LANE_W'(i)) begin
        w_selHash  = i_hash_out[i*HASH_W +: HASH_W];
        w_selNonce = i_hash_nonce[i*NONCE_W +: NONCE_W];
      end
    end
  end

  // Pick the current chunk pair, counting chunks from the MS end
  always_comb begin
    w_tChunk = '0;
    w_hChunk = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (r_k == K_W'(c)) begin
        w_tChunk = r_target[HASH_W-1-c*CHUNK_W -: CHUNK_W];
        w_hChunk = w_selHash[HASH_W-1-c*CHUNK_W -: CHUNK_W];
      end
    end
  end

  // Chunk decision: an equal final chunk counts as a miss (strict less-than)
  assign w_gt           = (w_tChunk > w_hChunk);
  assign w_lt           = (w_tChunk < w_hChunk);
  assign w_eq           = ~w_gt & ~w_lt;
  assign w_lastChunk    = (r_k == K_W'(NCHUNK - 1));
  assign w_inCompare    = (r_state == S_COMPARE) & ~i_stop;
  assign w_hit          = w_inCompare & w_gt;
  assign w_miss         = w_inCompare & (w_lt | (w_eq & w_lastChunk));
  assign w_chunkAdvance = w_inCompare & w_eq & ~w_lastChunk;
  assign w_arbTake      = (r_state == S_ARB) & ~i_stop & w_arbFound;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_DRAIN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state decode; stop always returns to DRAIN
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_DRAIN: begin
        if (w_drainIdle && i_start) w_nextState = S_LOAD_TARGET;
      end
      S_LOAD_TARGET: begin
        if (i_stop)         w_nextState = S_DRAIN;
        else if (w_cntFull) w_nextState = S_ARB;
      end
      S_ARB: begin
        if (i_stop)          w_nextState = S_DRAIN;
        else if (w_arbFound) w_nextState = S_COMPARE;
      end
      S_COMPARE: begin
        if (i_stop)      w_nextState = S_DRAIN;
        else if (w_hit)  w_nextState = S_DRAIN;
        else if (w_miss) w_nextState = S_ARB;
      end
      default: w_nextState = S_DRAIN;
    endcase
  end

  // FSM outputs: drain pops every non-empty lane, compare pops the retired head
  always_comb begin
    o_hash_re      = '0;
    o_target_ready = 1'b0;
    o_stop_ack     = 1'b0;
    case (r_state)
      S_DRAIN: begin
        o_hash_re  = ~i_hash_empty;
        o_stop_ack = w_drainIdle;
      end
      S_LOAD_TARGET: begin
        o_target_ready = (r_cnt < CNT_W'(NWORDS));
      end
      S_COMPARE: begin
        for (int i = 0; i < LANES; i++) begin
          if ((w_hit || w_miss) && (r_sel == LANE_W'(i))) o_hash_re[i] = 1'b1;
        end
      end
      default: begin
        o_hash_re = '0;
      end
    endcase
  end

  // Datapath: target shift-in, arbitration bookkeeping and golden capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_target      <= '0;
      r_cnt         <= '0;
      r_rrPtr       <= '0;
      r_sel         <= '0;
      r_k           <= '0;
      r_result      <= 1'b0;
      r_goldenNonce <= '0;
      r_goldenLane  <= '0;
    end else begin
      if (w_startAccept) begin
        r_result <= 1'b0;
        r_cnt    <= '0;
      end
      if (w_targetFire) begin
        r_target <= {i_target_word, r_target[HASH_W-1:TGT_WORD_W]};
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_arbTake) begin
        r_sel <= w_arbLane;
        r_k   <= '0;
      end
      if (w_chunkAdvance) begin
        r_k <= r_k + 1'b1;
      end
      if (w_hit) begin
        r_result      <= 1'b1;
        r_goldenNonce <= w_selNonce;
        r_goldenLane  <= r_sel;
      end
      if (w_miss) begin
        r_rrPtr <= w_selNext;
      end
    end
  end

  assign o_result       = r_result;
  assign o_golden_nonce = r_goldenNonce;
  assign o_golden_lane  = r_goldenLane;

`ifdef HASH_CMP_DBG_EN
  logic [31:0] r_dbgHashCnt;

  // Saturating count of hashes retired in COMPARE since the last start
  always_ff @(posedge i_clk) begin
    if (i_rst || w_startAccept) begin
      r_dbgHashCnt <= '0;
    end else if ((w_hit || w_miss) && (r_dbgHashCnt != 32'hFFFF_FFFF)) begin
      r_dbgHashCnt <= r_dbgHashCnt + 32'd1;
    end
  end

  assign o_dbg_state    = r_state;
  assign o_dbg_target   = r_target;
  assign o_dbg_hash_cnt = r_dbgHashCnt;
`endif

endmodule

// File: tb/tb_hash_target_cmp_multi.sv
// tb_hash_target_cmp_multi
// Directed bench for hash_target_cmp_multi with the default parameters.
// Stimulus pushes hashes into per-lane FIFO models and queues the expected
// pop events; a monitor matches each DUT pop against that queue and checks
// the result registers one cycle later.

module tb_hash_target_cmp_multi;

  localparam int HASH_W     = 256;
  localparam int TGT_WORD_W = 32;
  localparam int CHUNK_W    = 64;
  localparam int LANES      = 4;
  localparam int NONCE_W    = 32;
  localparam int LANE_W     = 2;

  localparam logic [HASH_W-1:0] TARGET =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [HASH_W-1:0] TARGET_M1 =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000000;

  typedef struct {
    logic [HASH_W-1:0]  hash;
    logic [NONCE_W-1:0] nonce;
  } laneEntryT;

  typedef struct {
    logic [LANES-1:0]   mask;
    logic               res;
    logic               hit;
    logic [LANE_W-1:0]  lane;
    logic [NONCE_W-1:0] nonce;
  } expT;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     stop;
  logic                     stopAck;
  logic [TGT_WORD_W-1:0]    targetWord;
  logic                     targetValid;
  logic                     targetReady;
  logic                     upstreamAllEmpty;
  logic [LANES*HASH_W-1:0]  hashOut;
  logic [LANES*NONCE_W-1:0] hashNonce;
  logic [LANES-1:0]         hashEmpty;
  logic [LANES-1:0]         hashRe;
  logic                     result;
  logic [NONCE_W-1:0]       goldenNonce;
  logic [LANE_W-1:0]        goldenLane;

  laneEntryT laneQ [LANES][$];
  expT       expQ[$];
  int        popCycles[$];
  int        cycleCnt = 0;
  int        checksTotal = 0;
  int        checksPassed = 0;
  bit        pendValid = 1'b0;
  expT       pendExp;
  int        startCyc;

  always #5 clk = ~clk;

  hash_target_cmp_multi #(
    .HASH_W(HASH_W), .TGT_WORD_W(TGT_WORD_W), .CHUNK_W(CHUNK_W),
    .LANES(LANES), .NONCE_W(NONCE_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_stop(stop),
    .o_stop_ack(stopAck),
    .i_target_word(targetWord),
    .i_target_valid(targetValid),
    .o_target_ready(targetReady),
    .i_upstream_all_empty(upstreamAllEmpty),
    .i_hash_out(hashOut),
    .i_hash_nonce(hashNonce),
    .i_hash_empty(hashEmpty),
    .o_hash_re(hashRe),
    .o_result(result),
    .o_golden_nonce(goldenNonce),
    .o_golden_lane(goldenLane)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Present the head of every lane FIFO model to the DUT
  task automatic updateHeads();
    for (int i = 0; i < LANES; i++) begin
      if (laneQ[i].size() > 0) begin
        hashOut[i*HASH_W +: HASH_W]    = laneQ[i][0].hash;
        hashNonce[i*NONCE_W +: NONCE_W] = laneQ[i][0].nonce;
        hashEmpty[i] = 1'b0;
      end else begin
        hashOut[i*HASH_W +: HASH_W]    = '0;
        hashNonce[i*NONCE_W +: NONCE_W] = '0;
        hashEmpty[i] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input int lane, input logic [HASH_W-1:0] h, input logic [NONCE_W-1:0] n);
    laneEntryT e;
    e.hash  = h;
    e.nonce = n;
    laneQ[lane].push_back(e);
    updateHeads();
  endtask

  task automatic expectPop(input logic [LANES-1:0] mask, input logic res, input logic hit,
                           input logic [LANE_W-1:0] lane, input logic [NONCE_W-1:0] nonce);
    expT x;
    x.mask = mask; x.res = res; x.hit = hit; x.lane = lane; x.nonce = nonce;
    expQ.push_back(x);
  endtask

  function automatic logic [HASH_W-1:0] mkMiss(input int tag);
    return {64'hFFFF_FFFF_0000_0000 | 64'(tag), 192'(tag)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic startSearch();
    start = 1'b1;
    startCyc = cycleCnt;
    tick();
    start = 1'b0;
  endtask

  // Shift in words 1..8, one per cycle, LS word first
  task automatic loadTarget();
    for (int w = 1; w <= HASH_W / TGT_WORD_W; w++) begin
      targetWord  = TGT_WORD_W'(w);
      targetValid = 1'b1;
      if (w == 1) checkOutput("target_ready_first_beat", 64'(targetReady), 64'd1);
      tick();
    end
    targetValid = 1'b0;
    checkOutput("target_ready_after_8_beats", 64'(targetReady), 64'd0);
  endtask

  task automatic waitPops(input int n, input string name);
    int budget = 0;
    while (popCycles.size() < n && budget < 200) begin
      tick();
      budget++;
    end
    checkOutput({name, "_pop_count"}, 64'(popCycles.size()), 64'(n));
  endtask

  task automatic waitDrained(input string name);
    int budget = 0;
    while ((expQ.size() != 0 || pendValid) && budget < 200) begin
      tick();
      budget++;
    end
    checkOutput({name, "_expected_pops_left"}, 64'(expQ.size()), 64'd0);
  endtask

  // Lane FIFO models: sample pops at the edge, retire them just after it
  always @(posedge clk) begin
    logic [LANES-1:0] popMask;
    cycleCnt++;
    popMask = hashRe;
    #1;
    for (int i = 0; i < LANES; i++) begin
      if (popMask[i] && laneQ[i].size() > 0) void'(laneQ[i].pop_front());
    end
    updateHeads();
  end

  // Monitor: match each pop against the scoreboard, check results a cycle later
  always @(negedge clk) begin
    if (pendValid) begin
      checkOutput("result_after_pop", 64'(result), 64'(pendExp.res));
      if (pendExp.hit) begin
        checkOutput("golden_lane", 64'(goldenLane), 64'(pendExp.lane));
        checkOutput("golden_nonce", 64'(goldenNonce), 64'(pendExp.nonce));
      end
      pendValid = 1'b0;
    end
    if (!rst && hashRe != '0) begin
      popCycles.push_back(cycleCnt);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pop", 64'(hashRe), 64'd0);
      end else begin
        pendExp = expQ.pop_front();
        checkOutput("pop_mask", 64'(hashRe), 64'(pendExp.mask));
        pendValid = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    targetWord = '0; targetValid = 1'b0; upstreamAllEmpty = 1'b1;
    hashOut = '0; hashNonce = '0; hashEmpty = '1;
    updateHeads();
    repeat (3) tick();

    // Reset state
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_golden_nonce", 64'(goldenNonce), 64'd0);
    checkOutput("reset_golden_lane", 64'(goldenLane), 64'd0);
    checkOutput("reset_target_ready", 64'(targetReady), 64'd0);
    checkOutput("reset_stop_ack", 64'(stopAck), 64'd1);
    checkOutput("reset_hash_re", 64'(hashRe), 64'd0);
    rst = 1'b0;
    tick();

    // Four lanes of misses: round-robin order 0,1,2,3,0, two cycles each
    $display("[TB] round-robin miss sweep");
    popCycles.delete();
    startSearch();
    applyStimulus(0, mkMiss(16'h10), 32'h100);
    applyStimulus(0, mkMiss(16'h11), 32'h101);
    applyStimulus(1, mkMiss(16'h12), 32'h102);
    applyStimulus(2, mkMiss(16'h13), 32'h103);
    applyStimulus(3, mkMiss(16'h14), 32'h104);
    expectPop(4'b0001, 1'b0, 1'b0, '0, '0);
    expectPop(4'b0010, 1'b0, 1'b0, '0, '0);
    expectPop(4'b0100, 1'b0, 1'b0, '0, '0);
    expectPop(4'b1000, 1'b0, 1'b0, '0, '0);
    expectPop(4'b0001, 1'b0, 1'b0, '0, '0);
    loadTarget();
    waitPops(5, "rr");
    if (popCycles.size() >= 5) begin
      for (int i = 1; i < 5; i++)
        checkOutput("rr_pop_spacing", 64'(popCycles[i] - popCycles[i-1]), 64'd2);
    end
    waitDrained("rr");

    // Stop during COMPARE with all lanes non-empty
    $display("[TB] stop during compare");
    upstreamAllEmpty = 1'b0;
    for (int i = 0; i < LANES; i++) applyStimulus(i, mkMiss(16'h20 + i), 32'h200 + i);
    tick();
    stop = 1'b1;
    expectPop(4'b1111, 1'b0, 1'b0, '0, '0);
    tick();
    stop = 1'b0;
    checkOutput("stop_ack_lanes_busy", 64'(stopAck), 64'd0);
    tick();
    checkOutput("stop_ack_upstream_busy", 64'(stopAck), 64'd0);
    upstreamAllEmpty = 1'b1;
    #1;
    checkOutput("stop_ack_drained", 64'(stopAck), 64'd1);
    waitDrained("stop");

    // Hash equal to target is a miss
    $display("[TB] equal hash");
    popCycles.delete();
    startSearch();
    applyStimulus(2, TARGET, 32'h22);
    expectPop(4'b0100, 1'b0, 1'b0, '0, '0);
    loadTarget();
    waitPops(1, "equal");
    waitDrained("equal");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_ack_after_arb_stop", 64'(stopAck), 64'd1);

    // Target minus one: hit decided at the last chunk
    $display("[TB] golden hit in lane 2");
    popCycles.delete();
    startSearch();
    applyStimulus(2, TARGET_M1, 32'hCAFE_0002);
    expectPop(4'b0100, 1'b1, 1'b1, 2'd2, 32'hCAFE_0002);
    loadTarget();
    waitPops(1, "hit");
    if (popCycles.size() >= 1)
      checkOutput("hit_pop_latency_from_start", 64'(popCycles[0] - startCyc), 64'd14);
    waitDrained("hit");
    checkOutput("stop_ack_after_hit", 64'(stopAck), 64'd1);

    // Reset during COMPARE after an earlier hit
    $display("[TB] reset during compare");
    startSearch();
    checkOutput("result_cleared_by_start", 64'(result), 64'd0);
    checkOutput("golden_nonce_held", 64'(goldenNonce), 64'hCAFE_0002);
    applyStimulus(3, TARGET, 32'h33);
    applyStimulus(0, mkMiss(16'h30), 32'h30);
    loadTarget();
    tick();
    tick();
    rst = 1'b1;
    expectPop(4'b1001, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_golden_nonce", 64'(goldenNonce), 64'd0);
    checkOutput("rst_golden_lane", 64'(goldenLane), 64'd0);
    waitDrained("rst");
    checkOutput("stop_ack_after_rst_drain", 64'(stopAck), 64'd1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
